// File: rtl/predictor_pkg.sv
// Shared helpers for saturating-counter branch predictors.
// Reset value and saturating step functions used by the counter tables.
package predictor_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t sat_max(int w);
    if (w >= WORD_W) return '1;
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Weakly not-taken: one below the MSB-set threshold.
  function automatic word_t ctr_init(int w);
    return (word_t'(1) << (w - 1)) - word_t'(1);
  endfunction

  function automatic word_t sat_inc(word_t v, int w);
    return (v >= sat_max(w)) ? v : v + word_t'(1);
  endfunction

  function automatic word_t sat_dec(word_t v);
    return (v == '0) ? v : v - word_t'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One CTR_W-bit saturating up/down counter entry.
// Counts toward taken when DIR=1, toward not-taken when DIR=0.
module sat_counter
  import predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             CLOCK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             DIR,
  output logic [CTR_W-1:0] VALUE
);

  localparam logic [CTR_W-1:0] INIT_V = CTR_W'(ctr_init(CTR_W));

  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      VALUE <= INIT_V;
    end else if (EN) begin
      if (DIR) VALUE <= CTR_W'(sat_inc(word_t'(VALUE), CTR_W));
      else     VALUE <= CTR_W'(sat_dec(word_t'(VALUE)));
    end
  end

endmodule

// File: rtl/sat_counter_predictor.sv
// Bimodal / gshare direction predictor over a table of saturating counters,
// with saturating lookup and misprediction statistics.
module sat_counter_predictor
  import predictor_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 0,
  parameter int MISS_W = 16
) (
  input  logic              CLOCK,
  input  logic              INIT,
  input  logic [IDX_W-1:0]  ADDR,
  input  logic              VALID,
  input  logic              OUTCOME,
  output logic              PREDICTION,
  output logic              MISS_PULSE,
  output logic [MISS_W-1:0] MISSES,
  output logic [MISS_W-1:0] LOOKUPS
);

  localparam int N = 2 ** IDX_W;

  if (HIST_W < 0 || HIST_W > IDX_W) begin : g_bad_hist
    $error("HIST_W must be in 0..IDX_W");
  end
  if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr
    $error("CTR_W must be in 1..4");
  end
  if (MISS_W < 1 || MISS_W > WORD_W) begin : g_bad_miss
    $error("MISS_W must be in 1..32");
  end

  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] ctr [N];
  logic [CTR_W-1:0] sel_ctr;
  logic             mispredict;
  logic             unused_ctr;

  if (HIST_W == 0) begin : g_bimodal
    assign idx = ADDR;
  end else begin : g_gshare
    logic [HIST_W-1:0] ghr;

    // Shift in the newest outcome at the LSB; the oldest bit falls off.
    always_ff @(posedge CLOCK) begin
      if (INIT)       ghr <= '0;
      else if (VALID) ghr <= HIST_W'({ghr, OUTCOME});
    end

    assign idx = ADDR ^ IDX_W'(ghr);
  end

  for (genvar i = 0; i < N; i++) begin : g_entry
    sat_counter #(
      .CTR_W(CTR_W)
    ) u_ctr (
      .CLOCK(CLOCK),
      .INIT (INIT),
      .EN   (VALID && (idx == IDX_W'(i))),
      .DIR  (OUTCOME),
      .VALUE(ctr[i])
    );
  end

  assign sel_ctr    = ctr[idx];
  assign PREDICTION = sel_ctr[CTR_W-1];
  assign mispredict = PREDICTION != OUTCOME;
  assign unused_ctr = ^sel_ctr;

  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      MISSES     <= '0;
      LOOKUPS    <= '0;
      MISS_PULSE <= 1'b0;
    end else begin
      MISS_PULSE <= 1'b0;
      if (VALID) begin
        MISS_PULSE <= mispredict;
        LOOKUPS    <= MISS_W'(sat_inc(word_t'(LOOKUPS), MISS_W));
        if (mispredict)
          MISSES <= MISS_W'(sat_inc(word_t'(MISSES), MISS_W));
      end
    end
  end

endmodule
